// File: rtl/pipe_scan_ctrl_if.sv
// Collision-checker bus between pipe_scan_ctrl and the shared collision unit.
// master drives chk_pipe_x/chk_pipe_y/chk_valid; slave returns collision_in.
interface pipe_scan_ctrl_if #(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
);
  logic [WIDTH-1:0]  chk_pipe_x;
  logic [HEIGHT-1:0] chk_pipe_y;
  logic              chk_valid;
  logic              collision_in;

  modport master (
    output chk_pipe_x,
    output chk_pipe_y,
    output chk_valid,
    input  collision_in
  );

  modport slave (
    input  chk_pipe_x,
    input  chk_pipe_y,
    input  chk_valid,
    output collision_in
  );
endinterface

// File: rtl/pipe_scan_ctrl.sv
// Flappy-bird game-state controller: per-frame time-shared collision scan,
// floor check, idle/play/over sequencing, run gating and pass scoring.
// Ports: clk, reset (sync, active high), frame_tick, start_btn,
//   pipe_x_in/pipe_y_in (packed slots), bird_y, bus (collision checker,
//   master side), game_state, run, game_over, score. All outputs registered.
module pipe_scan_ctrl #(
  parameter int NUM_PIPES  = 4,
  parameter int WIDTH      = 10,
  parameter int HEIGHT     = 10,
  parameter int BIRD_X     = 200,
  parameter int PIPE_WIDTH = 30,
  parameter int FLOOR_Y    = 460,
  parameter int SCORE_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        start_btn,
  input  logic [NUM_PIPES*WIDTH-1:0]  pipe_x_in,
  input  logic [NUM_PIPES*HEIGHT-1:0] pipe_y_in,
  input  logic [HEIGHT-1:0]           bird_y,
  pipe_scan_ctrl_if.master            bus,
  output logic [1:0]                  game_state,
  output logic                        run,
  output logic                        game_over,
  output logic [SCORE_W-1:0]          score
);

  localparam int IDX_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 start_q;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 hit_q, hit_d;
  logic [NUM_PIPES-1:0] passed_q, passed_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [WIDTH-1:0]     x_q, x_d;
  logic [HEIGHT-1:0]    y_q, y_d;
  logic                 run_q, run_d;
  logic                 over_q, over_d;

  logic                 start_edge;
  logic                 last;
  logic                 hit_now;
  logic [IDX_W-1:0]     ld_idx;
  logic [WIDTH-1:0]     slot_x;
  logic [HEIGHT-1:0]    slot_y;
  logic [WIDTH:0]       x_ext;
  logic                 gone_left;
  logic                 gone_right;

  assign start_edge = start_btn & ~start_q;
  assign last       = (idx_q == IDX_W'(NUM_PIPES - 1));
  assign hit_now    = hit_q | bus.collision_in;

  // Slot to present next: slot 0 on a tick, otherwise the following slot.
  assign ld_idx = valid_q ? (idx_q + IDX_W'(1)) : '0;

  always_comb begin
    slot_x = '0;
    slot_y = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (ld_idx == IDX_W'(i)) begin
        slot_x = pipe_x_in[i*WIDTH +: WIDTH];
        slot_y = pipe_y_in[i*HEIGHT +: HEIGHT];
      end
    end
  end

  // One extra bit so pipe_x + PIPE_WIDTH cannot wrap.
  assign x_ext      = {1'b0, x_q} + (WIDTH+1)'(PIPE_WIDTH);
  assign gone_left  = x_ext < (WIDTH+1)'(BIRD_X);
  assign gone_right = x_q > WIDTH'(BIRD_X);

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    passed_d = passed_q;
    score_d  = score_q;
    x_d      = x_q;
    y_d      = y_q;

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d  = PLAY;
          score_d  = '0;
          passed_d = '0;
          hit_d    = 1'b0;
        end
      end

      PLAY: begin
        if (!valid_q) begin
          if (frame_tick) begin
            valid_d = 1'b1;
            idx_d   = '0;
            hit_d   = (bird_y >= HEIGHT'(FLOOR_Y));
            x_d     = slot_x;
            y_d     = slot_y;
          end
        end else begin
          hit_d = hit_now;
          if (gone_left && !passed_q[idx_q]) begin
            passed_d[idx_q] = 1'b1;
            if (score_q != '1) begin
              score_d = score_q + SCORE_W'(1);
            end
          end else if (gone_right) begin
            passed_d[idx_q] = 1'b0;
          end
          if (last) begin
            valid_d = 1'b0;
            idx_d   = '0;
            if (hit_now) begin
              state_d = OVER;
            end
          end else begin
            idx_d = ld_idx;
            x_d   = slot_x;
            y_d   = slot_y;
          end
        end
      end

      OVER: begin
        if (start_edge) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    run_d  = (state_d == PLAY);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      passed_q <= '0;
      score_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      run_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_btn;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      passed_q <= passed_d;
      score_q  <= score_d;
      x_q      <= x_d;
      y_q      <= y_d;
      run_q    <= run_d;
      over_q   <= over_d;
    end
  end

  assign bus.chk_pipe_x = x_q;
  assign bus.chk_pipe_y = y_q;
  assign bus.chk_valid  = valid_q;
  assign game_state     = state_q;
  assign run            = run_q;
  assign game_over      = over_q;
  assign score          = score_q;

endmodule

// File: tb/tb_pipe_scan_ctrl.sv
// Scoreboard bench for pipe_scan_ctrl: a frame-level game model queues the
// expected scan beats; a negedge monitor pops and checks them.
module tb_pipe_scan_ctrl;

  localparam int NP = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_tick = 1'b0;
  logic              start_btn = 1'b0;
  logic [NP*10-1:0]  pipe_x_in;
  logic [NP*10-1:0]  pipe_y_in;
  logic [9:0]        bird_y = 10'd100;
  logic [1:0]        game_state;
  logic              run;
  logic              game_over;
  logic [7:0]        score;
  logic              junk = 1'b0;

  logic [9:0] px [NP];
  logic [9:0] py [NP];

  pipe_scan_ctrl_if #(.WIDTH(10), .HEIGHT(10)) bus ();

  pipe_scan_ctrl #(
    .NUM_PIPES(NP), .WIDTH(10), .HEIGHT(10), .BIRD_X(200),
    .PIPE_WIDTH(30), .FLOOR_Y(460), .SCORE_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame_tick(frame_tick),
    .start_btn(start_btn),
    .pipe_x_in(pipe_x_in),
    .pipe_y_in(pipe_y_in),
    .bird_y(bird_y),
    .bus(bus),
    .game_state(game_state),
    .run(run),
    .game_over(game_over),
    .score(score)
  );

  always #5 clk = ~clk;

  // Collision unit stand-in: a pipe with gap y == 7 collides; while no
  // check is requested the line carries random noise.
  always @(posedge clk) junk <= 1'($urandom);
  assign bus.collision_in = bus.chk_valid ? (bus.chk_pipe_y == 10'd7) : junk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      pipe_x_in[i*10 +: 10] = px[i];
      pipe_y_in[i*10 +: 10] = py[i];
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Game model
  typedef struct {
    int x;
    int y;
    int score;
    bit last;
    int st;
  } beat_t;

  beat_t beats[$];
  beat_t pend;
  bit    pend_v = 1'b0;

  int m_state = 0;
  int m_score = 0;
  bit m_passed [NP];

  task automatic model_clear();
    for (int i = 0; i < NP; i++) m_passed[i] = 1'b0;
  endtask

  task automatic model_frame(input int by);
    bit hit;
    beat_t b;
    if (m_state != 1) return;
    hit = (by >= 460);
    for (int i = 0; i < NP; i++) begin
      int x;
      x = int'(px[i]);
      if (py[i] == 10'd7) hit = 1'b1;
      if (x + 30 < 200) begin
        if (!m_passed[i]) begin
          m_passed[i] = 1'b1;
          if (m_score < 255) m_score++;
        end
      end else if (x > 200) begin
        m_passed[i] = 1'b0;
      end
      b.x = x;
      b.y = int'(py[i]);
      b.score = m_score;
      b.last = (i == NP - 1);
      if (b.last && hit) m_state = 2;
      b.st = m_state;
      beats.push_back(b);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (pend_v) begin
      pend_v = 1'b0;
      chk("score_after_beat", int'(score), pend.score);
      if (pend.last) begin
        chk("game_state_after_scan", int'(game_state), pend.st);
        chk("run_after_scan", int'(run), int'(pend.st == 1));
        chk("game_over_after_scan", int'(game_over), int'(pend.st == 2));
      end
    end
    if (bus.chk_valid) begin
      if (beats.size() == 0) begin
        chk("chk_valid_unexpected", int'(bus.chk_valid), 0);
      end else begin
        pend = beats.pop_front();
        pend_v = 1'b1;
        chk("chk_pipe_x", int'(bus.chk_pipe_x), pend.x);
        chk("chk_pipe_y", int'(bus.chk_pipe_y), pend.y);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    start_btn = 1'b1;
    if (m_state == 0) begin
      m_state = 1;
      m_score = 0;
      model_clear();
    end else if (m_state == 2) begin
      m_state = 0;
    end
    step();
    chk("state_after_start", int'(game_state), m_state);
    chk("run_after_start", int'(run), int'(m_state == 1));
    start_btn = 1'b0;
    step();
  endtask

  task automatic frame(input int by, input bit extra);
    bird_y = 10'(by);
    frame_tick = 1'b1;
    model_frame(by);
    step();
    for (int c = 1; c <= NP + 1; c++) begin
      frame_tick = (c == 2) && extra;
      step();
    end
    frame_tick = 1'b0;
    chk("beats_drained", beats.size(), 0);
    chk("score_model", int'(score), m_score);
  endtask

  task automatic set_pipes(input int x0, input int x1,
                           input int x2, input int x3);
    px[0] = 10'(x0);
    px[1] = 10'(x1);
    px[2] = 10'(x2);
    px[3] = 10'(x3);
    for (int i = 0; i < NP; i++) py[i] = 10'(100 + 50 * i);
  endtask

  initial begin
    set_pipes(400, 500, 600, 700);
    model_clear();

    // Reset and start
    step();
    step();
    chk("rst_state", int'(game_state), 0);
    chk("rst_run", int'(run), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_valid", int'(bus.chk_valid), 0);
    chk("rst_x", int'(bus.chk_pipe_x), 0);
    chk("rst_y", int'(bus.chk_pipe_y), 0);
    chk("rst_score", int'(score), 0);
    reset = 1'b0;
    step();
    start_btn = 1'b1;
    chk("state_before_edge", int'(game_state), 0);
    m_state = 1;
    step();
    chk("start_state", int'(game_state), 1);
    chk("start_run", int'(run), 1);
    repeat (3) step();
    chk("start_held_state", int'(game_state), 1);
    start_btn = 1'b0;
    step();

    // Clean scan
    frame(100, 1'b0);
    chk("clean_state", int'(game_state), 1);

    // Collision on slot 2
    py[2] = 10'd7;
    frame(100, 1'b0);
    chk("col_state", int'(game_state), 2);
    chk("col_run", int'(run), 0);
    chk("col_over", int'(game_over), 1);
    py[2] = 10'd200;
    press();
    press();

    // Floor
    frame(460, 1'b0);
    chk("floor_state", int'(game_state), 2);
    press();
    press();
    frame(459, 1'b0);
    chk("floor_459_state", int'(game_state), 1);

    // Scoring
    set_pipes(400, 169, 400, 400);
    repeat (3) frame(100, 1'b0);
    chk("score_once", int'(score), 1);
    px[1] = 10'd300;
    frame(100, 1'b0);
    px[1] = 10'd169;
    frame(100, 1'b0);
    chk("score_again", int'(score), 2);

    // Saturation
    for (int k = 0; k < 66; k++) begin
      set_pipes(169, 169, 169, 169);
      frame(100, 1'b0);
      set_pipes(300, 300, 300, 300);
      frame(100, 1'b0);
    end
    chk("score_sat", int'(score), 255);

    // Overlapping tick
    set_pipes(420, 430, 440, 450);
    frame(100, 1'b1);
    chk("overlap_state", int'(game_state), 1);

    // Mid-scan reset
    frame_tick = 1'b1;
    model_frame(100);
    step();
    frame_tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    beats.delete();
    pend_v = 1'b0;
    m_state = 0;
    m_score = 0;
    model_clear();
    chk("midrst_valid", int'(bus.chk_valid), 0);
    chk("midrst_state", int'(game_state), 0);
    chk("midrst_score", int'(score), 0);
    step();

    // Random play
    for (int k = 0; k < 150; k++) begin
      while (m_state != 1) press();
      for (int i = 0; i < NP; i++) begin
        case ($urandom_range(0, 3))
          0: px[i] = 10'd169;
          1: px[i] = 10'd300;
          default: px[i] = 10'($urandom_range(0, 1023));
        endcase
        py[i] = 10'($urandom_range(0, 15));
      end
      frame($urandom_range(380, 470), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
